// File: rtl/lock_code_sequencer.sv
// Keypad-style code lock fed by a UART byte stream; all outputs registered, one cycle after the sampling edge.
// No backpressure: rx_valid strobes are consumed or ignored in the cycle they arrive.
module lock_code_sequencer #(
    parameter int          CODE_LEN       = 4,
    parameter logic [63:0] CODE           = 64'h0000_0000_3132_3334,
    parameter int          MAX_FAIL       = 3,
    parameter int          OPEN_CYCLES    = 50_000_000,
    parameter int          LOCKOUT_CYCLES = 250_000_000,
    parameter int          TIMEOUT_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       lock_open,
    output logic       lockout,
    output logic       entry_active,
    output logic [1:0] fail_cnt,
    output logic       ok_pulse,
    output logic       err_pulse
);
    localparam int MAX_OL  = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int MAX_CYC = (MAX_OL > TIMEOUT_CYCLES) ? MAX_OL : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] OPEN_LOAD    = CNT_W'(OPEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCKOUT_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       CLOSE_CHAR   = 8'h43;

    typedef enum logic [1:0] {ST_IDLE, ST_ENTRY, ST_OPEN, ST_LOCKOUT} state_t;

    state_t           state, state_nx;
    logic [2:0]       idx, idx_nx;
    logic             mism, mism_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0]       fail_nx, fail_inc;
    logic             ok_nx, err_nx;
    logic             hit, close, byte_mism, eval, eval_mism;

    // First code character lives in the most significant used byte.
    function automatic logic [7:0] char_at(input logic [2:0] i);
        return 8'(CODE >> (8 * (CODE_LEN - 1 - int'(i))));
    endfunction

    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        mism_nx   = mism;
        cnt_nx    = (cnt == '0) ? cnt : cnt - CNT_W'(1);
        fail_nx   = fail_cnt;
        ok_nx     = 1'b0;
        err_nx    = 1'b0;
        eval      = 1'b0;
        eval_mism = 1'b0;
        hit       = rx_valid && (rx_byte != CLOSE_CHAR);
        close     = rx_valid && (rx_byte == CLOSE_CHAR);
        byte_mism = (rx_byte != char_at(idx));
        fail_inc  = (int'(fail_cnt) < MAX_FAIL) ? fail_cnt + 2'd1 : fail_cnt;

        case (state)
            ST_IDLE: begin
                if (hit) begin
                    if (CODE_LEN == 1) begin
                        eval      = 1'b1;
                        eval_mism = byte_mism;
                    end else begin
                        state_nx = ST_ENTRY;
                        idx_nx   = 3'd1;
                        mism_nx  = byte_mism;
                        cnt_nx   = TIMEOUT_LOAD;
                    end
                end
            end
            ST_ENTRY: begin
                // A byte arriving on the expiry edge takes priority over the timeout.
                if (close) begin
                    state_nx = ST_IDLE;
                end else if (hit) begin
                    if (int'(idx) == CODE_LEN - 1) begin
                        eval      = 1'b1;
                        eval_mism = mism | byte_mism;
                    end else begin
                        idx_nx  = idx + 3'd1;
                        mism_nx = mism | byte_mism;
                        cnt_nx  = TIMEOUT_LOAD;
                    end
                end else if (cnt == '0) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_OPEN: begin
                if (close || cnt == '0)
                    state_nx = ST_IDLE;
            end
            ST_LOCKOUT: begin
                if (cnt == '0) begin
                    state_nx = ST_IDLE;
                    fail_nx  = 2'd0;
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        if (eval) begin
            if (!eval_mism) begin
                state_nx = ST_OPEN;
                cnt_nx   = OPEN_LOAD;
                fail_nx  = 2'd0;
                ok_nx    = 1'b1;
            end else begin
                err_nx  = 1'b1;
                fail_nx = fail_inc;
                if (int'(fail_inc) == MAX_FAIL) begin
                    state_nx = ST_LOCKOUT;
                    cnt_nx   = LOCKOUT_LOAD;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
        end

        if (state_nx == ST_IDLE && (state != ST_IDLE || eval)) begin
            idx_nx  = 3'd0;
            mism_nx = 1'b0;
            cnt_nx  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            idx          <= 3'd0;
            mism         <= 1'b0;
            cnt          <= '0;
            fail_cnt     <= 2'd0;
            lock_open    <= 1'b0;
            lockout      <= 1'b0;
            entry_active <= 1'b0;
            ok_pulse     <= 1'b0;
            err_pulse    <= 1'b0;
        end else begin
            state        <= state_nx;
            idx          <= idx_nx;
            mism         <= mism_nx;
            cnt          <= cnt_nx;
            fail_cnt     <= fail_nx;
            lock_open    <= (state_nx == ST_OPEN);
            lockout      <= (state_nx == ST_LOCKOUT);
            entry_active <= (state_nx == ST_ENTRY);
            ok_pulse     <= ok_nx;
            err_pulse    <= err_nx;
        end
    end
endmodule
